// File: rtl/sprite_rom_arbiter.sv
// Two-requester arbiter for a shared falling-edge sprite ROM: round-robin with a burst limit.
// Define SPRITE_ROM_ARB_FIXED_PRI_EN to give requester 1 (sprite) absolute priority instead.
module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              vld0,
    output logic              vld1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q
);

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    // State names the requester granted at the last edge.
    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          burst_q, burst_d;
    logic                last_owner_q, last_owner_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                vld0_q, vld0_d;
    logic                vld1_q, vld1_d;
    logic [DATA_W-1:0]   data0_q, data0_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;

    // State register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            burst_q      <= 8'd0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state: the next state is also the grant decision for this edge.
    always_comb begin
        state_d = StIdle;
`ifdef SPRITE_ROM_ARB_FIXED_PRI_EN
        if (req1) begin
            state_d = StOwn1;
        end else if (req0) begin
            state_d = StOwn0;
        end
`else
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (req0 && req1) begin
                    state_d = (burst_q >= MaxBurst) ? StOwn1 : StOwn0;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn1: begin
                if (req0 && req1) begin
                    state_d = (burst_q >= MaxBurst) ? StOwn0 : StOwn1;
                end else if (req1) begin
                    state_d = StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end
            end
            default: state_d = StIdle;
        endcase
`endif
    end

    // Outputs and datapath next values
    always_comb begin
        gnt0_d        = (state_d == StOwn0);
        gnt1_d        = (state_d == StOwn1);
        rom_address_d = rom_address_q;
        burst_d       = burst_q;
        last_owner_d  = last_owner_q;
        // ROM answered on the falling edge for the address granted at the last rising edge.
        vld0_d        = gnt0_q;
        vld1_d        = gnt1_q;
        data0_d       = gnt0_q ? rom_q : data0_q;
        data1_d       = gnt1_q ? rom_q : data1_q;
        if (state_d != StIdle) begin
            rom_address_d = gnt1_d ? addr1 : addr0;
            last_owner_d  = gnt1_d;
            if (state_d == state_q) begin
                burst_d = (burst_q >= MaxBurst) ? MaxBurst : burst_q + 8'd1;
            end else begin
                burst_d = 8'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            vld0_q        <= 1'b0;
            vld1_q        <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
            rom_address_q <= '0;
        end else begin
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            vld0_q        <= vld0_d;
            vld1_q        <= vld1_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            rom_address_q <= rom_address_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign vld0        = vld0_q;
    assign vld1        = vld1_q;
    assign data0       = data0_q;
    assign data1       = data1_q;
    assign rom_address = rom_address_q;

endmodule
